tt_capture_7in: RTL and testbench
=================================

// Module: tt_capture_7in
// PURPOSE
//  Reads back a 7-input combinational classification network (a majority-gate cone) as a truth table.
//  Steps x[6:0] through all 2^NIN minterms and samples the network output f_in once per minterm.
//  Assembles the results into a truth-table vector.
//  Streams that vector as hex nibbles, MSB first, on a valid/ready port.
//  Sits in the bench/FPGA harness between the stimulus controller and the result logger.
// PARAMETERS
//  NIN    7  number of network inputs (>=2); TT width = 2^NIN, nibble count = 2^NIN/4
//  SETTLE 2  extra cycles x_out is held before f_in is sampled (0..255)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        begin capture; sampled in IDLE only
//  abort      in   1        synchronous return to IDLE from any state
//  x_out      out  NIN      minterm driven into network; x_out[0] = x0
//  f_in       in   1        network output for current x_out
//  busy       out  1        high in WAIT and STREAM
//  done       out  1        one-cycle pulse after last nibble accepted
//  tt         out  2^NIN    captured truth table; bit i = f(x_out==i)
//  hex_valid  out  1        nibble available
//  hex_ready  in   1        consumer accepts nibble when valid&ready
//  hex_data   out  4        nibble; first = tt[2^NIN-1 -: 4]
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; x_out=0, tt=0, busy=0, done=0, hex_valid=0, hex_data=0.
//  States: IDLE, WAIT, STREAM.
//  IDLE: start=1 -> idx=0, x_out=0, cnt=SETTLE, tt cleared to 0, go WAIT.
//  IDLE: done deasserts the cycle after its pulse.
//  WAIT: x_out=idx (registered) held stable.
//   cnt!=0: cnt--.
//   cnt==0: tt[idx]<=f_in at that edge.
//   cnt==0 and idx==2^NIN-1: go STREAM, nib=2^NIN/4-1.
//   cnt==0 otherwise: idx++, x_out<=idx+1, cnt<=SETTLE.
//  Minterm timing: each minterm is held SETTLE+1 cycles before sampling.
//  Capture phase: 2^NIN*(SETTLE+1) cycles; first hex_valid follows the cycle after the last sample.
//  STREAM: hex_valid=1, hex_data=tt[4*nib+3:4*nib].
//   Data stays stable until hex_ready=1.
//   valid&ready with nib>0: nib--, next nibble presented the following cycle.
//   valid&ready with nib==0: hex_valid<=0, done<=1 for one cycle, go IDLE.
//  Back-to-back transfer: hex_ready held 1 -> one nibble per cycle, 2^NIN/4 cycles.
//  x_out holds 2^NIN-1 during STREAM and after completion until next start.
//  start while busy: ignored; no restart.
//  abort: priority over all else; state=IDLE, hex_valid=0.
//   No done pulse; tt keeps partially written contents; x_out keeps its value.
//  abort and start in the same cycle: abort wins; start is not seen.
//  tt is readable at any time; it is final from the first STREAM cycle.
//  Reset mid-capture or mid-stream: all outputs return to reset values immediately.
// TESTING
//  T1 f_in=x0&x1, SETTLE=0, hex_ready=1 -> 32 nibbles all 4'h8.
//     tt=128'h8888...8; done 128+32 cycles after start.
//  T2 f_in=x6, SETTLE=2 -> tt = {64{1'b1}},{64{1'b0}}.
//     Stream = 16x'F' then 16x'0'; each x_out held 3 cycles.
//  T3 f_in=MAJ-network model of class feeaeeeafaeae880fee8a8a0a888a880.
//     Stream reads exactly that hex string, first nibble 'f'.
//  T4 hex_ready toggling 1-0-0-1 during STREAM -> hex_data stable while stalled.
//     No nibble dropped or duplicated; done only after 32nd accept.
//  T5 abort at idx=40 -> IDLE next cycle, no done, busy=0.
//     tt[39:0] captured, tt[127:40]=0; new start recaptures the full table.
//  T6 rst_n low mid-STREAM, start pulsed while busy -> reset values at once.
//     start-while-busy has no effect on idx or cnt.

Source files
------------

// File: rtl/tt_capture_7in.sv
// Truth-table capture engine: walks x_out through every minterm, samples f_in after a
// settle delay, then streams the captured table MSB-nibble-first over valid/ready.
module tt_capture_7in #(
  parameter int NIN    = 7,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [NIN-1:0]         x_out,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<NIN)-1:0]    tt,
  output logic                   hex_valid,
  input  logic                   hex_ready,
  output logic [3:0]             hex_data
);

  localparam int TTW  = 1 << NIN;
  localparam int NNIB = TTW / 4;
  localparam int NW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  localparam logic [NIN-1:0] IDX_LAST = {NIN{1'b1}};
  localparam logic [NW-1:0]  NIB_LAST = NW'(NNIB - 1);
  localparam logic [7:0]     CNT_INIT = 8'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM
  } state_t;

  state_t           r_state;
  logic [NIN-1:0]   r_idx;
  logic [7:0]       r_cnt;
  logic [TTW-1:0]   r_tt;
  logic [NW-1:0]    r_nib;
  logic             r_done;
  logic             r_hex_valid;
  logic [3:0]       r_hex_data;

  logic [NW-1:0]    w_nib_dec;
  logic [NW+1:0]    w_nib_base;

  assign w_nib_dec  = r_nib - NW'(1);
  assign w_nib_base = {w_nib_dec, 2'b00};

  // NOTE: every state register, including the whole tt vector, is cleared by the
  // async reset; tt is a visible output whose reset value is defined as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_tt        <= '0;
      r_nib       <= '0;
      r_done      <= 1'b0;
      r_hex_valid <= 1'b0;
      r_hex_data  <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state     <= S_IDLE;
        r_hex_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_idx   <= '0;
              r_cnt   <= CNT_INIT;
              r_tt    <= '0;
              r_state <= S_WAIT;
            end
          end

          S_WAIT: begin
            if (r_cnt != 8'd0) begin
              r_cnt <= r_cnt - 8'd1;
            end else begin
              r_tt[r_idx] <= f_in;
              if (r_idx == IDX_LAST) begin
                // The top nibble includes the bit being written at this same edge.
                r_state     <= S_STREAM;
                r_nib       <= NIB_LAST;
                r_hex_valid <= 1'b1;
                r_hex_data  <= {f_in, r_tt[TTW-2 -: 3]};
              end else begin
                r_idx <= r_idx + NIN'(1);
                r_cnt <= CNT_INIT;
              end
            end
          end

          S_STREAM: begin
            if (hex_ready) begin
              if (r_nib == '0) begin
                r_hex_valid <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_nib      <= w_nib_dec;
                r_hex_data <= r_tt[w_nib_base +: 4];
              end
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign x_out     = r_idx;
  assign busy      = (r_state == S_WAIT) || (r_state == S_STREAM);
  assign done      = r_done;
  assign tt        = r_tt;
  assign hex_valid = r_hex_valid;
  assign hex_data  = r_hex_data;

endmodule

// File: tb/tb_tt_capture_7in.sv
// Directed bench for tt_capture_7in: one instance with SETTLE=0, one with SETTLE=2,
// each fed by a behavioural model of the network under test.
module tb_tt_capture_7in;

  logic         clk;
  logic         rst_n;
  logic         hex_ready;

  logic         a_start, a_abort, a_f_in;
  logic [6:0]   a_x_out;
  logic         a_busy, a_done, a_hex_valid;
  logic [127:0] a_tt;
  logic [3:0]   a_hex_data;

  logic         b_start, b_abort, b_f_in;
  logic [6:0]   b_x_out;
  logic         b_busy, b_done, b_hex_valid;
  logic [127:0] b_tt;
  logic [3:0]   b_hex_data;

  logic         sel;
  logic [1:0]   a_mode;
  logic [127:0] class_tt;

  logic [6:0]   m_x_out;
  logic         m_busy, m_done, m_hex_valid;
  logic [3:0]   m_hex_data;

  int n_chk  = 0;
  int n_fail = 0;

  tt_capture_7in #(.NIN(7), .SETTLE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .x_out(a_x_out),
    .f_in(a_f_in), .busy(a_busy), .done(a_done), .tt(a_tt), .hex_valid(a_hex_valid),
    .hex_ready(hex_ready), .hex_data(a_hex_data)
  );

  tt_capture_7in #(.NIN(7), .SETTLE(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .x_out(b_x_out),
    .f_in(b_f_in), .busy(b_busy), .done(b_done), .tt(b_tt), .hex_valid(b_hex_valid),
    .hex_ready(hex_ready), .hex_data(b_hex_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Network models: 0 = x0&x1, 1 = x6, 2 = majority-network class table.
  always_comb begin
    a_f_in = 1'b0;
    case (a_mode)
      2'd0:    a_f_in = a_x_out[0] & a_x_out[1];
      2'd1:    a_f_in = a_x_out[6];
      default: a_f_in = class_tt[a_x_out];
    endcase
  end
  assign b_f_in = b_x_out[6];

  assign m_x_out     = sel ? b_x_out     : a_x_out;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_done      = sel ? b_done      : a_done;
  assign m_hex_valid = sel ? b_hex_valid : a_hex_valid;
  assign m_hex_data  = sel ? b_hex_data  : a_hex_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses start on the selected instance and runs it to the done pulse, collecting nibbles.
  task automatic run_capture(input int hold, input bit toggle, output logic [127:0] got,
                             output int nnib, output int cyc, output int stab_err,
                             output int hold_err);
    logic [3:0] prev_data;
    logic [6:0] prev_x;
    bit         prev_stall;
    int         run_len;
    int         phase;
    got = '0; nnib = 0; stab_err = 0; hold_err = 0;
    prev_stall = 1'b0; prev_data = '0; phase = 0;
    hex_ready = 1'b1;
    @(negedge clk);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;
    cyc = 1; prev_x = m_x_out; run_len = 1;
    while (!m_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (m_x_out != prev_x) begin
        if (run_len != hold || m_x_out != prev_x + 7'd1) hold_err++;
        prev_x = m_x_out; run_len = 1;
      end else begin
        run_len++;
      end
      if (m_hex_valid) begin
        if (prev_stall && m_hex_data != prev_data) stab_err++;
        hex_ready = toggle ? (phase == 0 || phase == 3) : 1'b1;
        phase = (phase + 1) % 4;
        if (hex_ready) begin
          got = {got[123:0], m_hex_data};
          nnib++;
        end
        prev_stall = !hex_ready;
        prev_data  = m_hex_data;
      end
    end
    hex_ready = 1'b1;
  endtask

  logic [127:0] got;
  int nnib, cyc, stab_err, hold_err, k, done_seen;

  initial begin
    class_tt  = 128'hfeeaeeeafaeae880fee8a8a0a888a880;
    rst_n     = 1'b0;
    hex_ready = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    sel = 1'b0; a_mode = 2'd0;
    #1;
    check("rst_x_out", a_x_out, 0);
    check("rst_tt", a_tt, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_hex_valid", a_hex_valid, 0);
    check("rst_hex_data", a_hex_data, 0);
    check("rst_b_tt", b_tt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1: f = x0&x1, SETTLE=0, ready held high
    a_mode = 2'd0; sel = 1'b0;
    run_capture(1, 1'b0, got, nnib, cyc, stab_err, hold_err);
    check("t1_tt", a_tt, {32{4'h8}});
    check("t1_stream", got, {32{4'h8}});
    check("t1_nibbles", nnib, 32);
    check("t1_done_cycle", cyc, 161);
    check("t1_x_hold", hold_err, 0);
    check("t1_x_final", a_x_out, 7'd127);
    @(negedge clk);
    check("t1_done_pulse", a_done, 0);
    check("t1_busy_idle", a_busy, 0);

    // T2: f = x6, SETTLE=2
    sel = 1'b1;
    run_capture(3, 1'b0, got, nnib, cyc, stab_err, hold_err);
    check("t2_tt", b_tt, {{64{1'b1}}, {64{1'b0}}});
    check("t2_stream", got, {{16{4'hf}}, {16{4'h0}}});
    check("t2_nibbles", nnib, 32);
    check("t2_done_cycle", cyc, 417);
    check("t2_x_hold", hold_err, 0);
    sel = 1'b0;

    // T3: majority-network class, ready held high
    a_mode = 2'd2;
    run_capture(1, 1'b0, got, nnib, cyc, stab_err, hold_err);
    check("t3_tt", a_tt, class_tt);
    check("t3_stream", got, class_tt);

    // T4: ready toggling 1-0-0-1 during STREAM
    run_capture(1, 1'b1, got, nnib, cyc, stab_err, hold_err);
    check("t4_stream", got, class_tt);
    check("t4_nibbles", nnib, 32);
    check("t4_stall_stable", stab_err, 0);

    // T5: abort while x_out = 40
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    k = 0;
    while (a_x_out != 7'd40 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("t5_reach_idx40", a_x_out, 7'd40);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("t5_busy", a_busy, 0);
    check("t5_hex_valid", a_hex_valid, 0);
    check("t5_x_out_kept", a_x_out, 7'd40);
    check("t5_tt_partial", a_tt, {88'd0, class_tt[39:0]});
    a_abort = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_abort = 1'b0; a_start = 1'b0;
    check("t5_abort_start_busy", a_busy, 0);
    check("t5_abort_start_tt", a_tt, {88'd0, class_tt[39:0]});
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_done) done_seen++;
    end
    check("t5_no_done", done_seen, 0);
    run_capture(1, 1'b0, got, nnib, cyc, stab_err, hold_err);
    check("t5_recapture_tt", a_tt, class_tt);
    check("t5_recapture_stream", got, class_tt);

    // T6: start while busy ignored, then reset mid-STREAM
    a_mode = 2'd1;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    k = 0;
    while (a_x_out != 7'd10 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("t6_reach_idx10", a_x_out, 7'd10);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("t6_start_busy_x", a_x_out, 7'd11);
    check("t6_start_busy_busy", a_busy, 1);
    k = 0;
    while (!a_hex_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("t6_stream_valid", a_hex_valid, 1);
    check("t6_first_nibble", a_hex_data, 4'hf);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    check("t6_stream_busy", a_busy, 1);
    check("t6_stream_x_out", a_x_out, 7'd127);
    check("t6_stream_nibble3", a_hex_data, 4'hf);
    rst_n = 1'b0;
    #1;
    check("t6_rst_x_out", a_x_out, 0);
    check("t6_rst_tt", a_tt, 0);
    check("t6_rst_busy", a_busy, 0);
    check("t6_rst_hex_valid", a_hex_valid, 0);
    check("t6_rst_hex_data", a_hex_data, 0);
    check("t6_rst_done", a_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_rst_busy", a_busy, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
